// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
// Types here are used by fetch_unit and fetch_buffer.
package fetch_pkg;

   localparam int INSTR_BYTES  = 4;
   localparam int FETCH_DATA_W = 32;
   localparam int FETCH_PC_W   = 32;

   // HALT is only reachable when the misalignment check is compiled in.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FULL = 2'd2,
      HALT = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic [FETCH_DATA_W-1:0] instr;
      logic [FETCH_PC_W-1:0]   pc;
   } fetch_entry_t;

   // Clear the byte-offset bits so the PC points at a whole instruction word.
   function automatic logic [FETCH_PC_W-1:0] align_pc(input logic [FETCH_PC_W-1:0] pc);
      return pc & ~(FETCH_PC_W'(INSTR_BYTES) - FETCH_PC_W'(1));
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: small synchronous FIFO of fetch_entry_t.
// Flush has priority over push/pop. Push while full is legal only together
// with a pop; the fetch credit scheme keeps that from ever being violated.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter  int BUF_DEPTH = 2,
   localparam int PTR_W     = $clog2(BUF_DEPTH),
   localparam int CNT_W     = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  fetch_entry_t     push_entry,
   output fetch_entry_t     head_entry,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUF_DEPTH);

   fetch_entry_t     mem_q [BUF_DEPTH];
   fetch_entry_t     mem_d [BUF_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign empty      = (count_q == '0);
   assign full       = (count_q == CNT_MAX);
   assign count      = count_q;
   assign head_entry = mem_q[rd_ptr_q];
   assign do_pop     = pop & ~empty;
   assign do_push    = push & (~full | do_pop);

   // Next storage, pointers and occupancy; flush empties the FIFO outright.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // FIFO state registers; storage is cleared so the head reads zero after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // A push into a full FIFO without a matching pop would lose an entry.
   assert property (@(posedge clk) disable iff (rst) !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of a 1-cycle-latency memory.
// Owns the PC, issues one word read per cycle while buffer credits allow,
// and hands {instruction, pc} to decode through instr_valid/ready.
// Optional build macro FETCH_MISALIGN_CHECK_EN adds the misaligned output and
// a HALT state entered on a redirect to a non word-aligned PC.
//
// Handshake: an entry transfers to decode on a rising edge where
// instr_valid & ready are both 1; instruction/instr_pc hold steady while
// instr_valid & ~ready. mem_valid answers the request of the previous cycle.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int          DataWidth = 32,
   parameter int          Address   = 8,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 redirect,
   input  logic [31:0]          redirect_pc,
   input  logic                 ready,
   output logic                 mem_request,
   output logic                 mem_we_re,
   output logic [3:0]           mem_mask,
   output logic [Address-1:0]   mem_address,
   input  logic                 mem_valid,
   input  logic [DataWidth-1:0] mem_data,
   output logic                 instr_valid,
   output logic [DataWidth-1:0] instruction,
   output logic [31:0]          instr_pc
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic                 misaligned
`endif
);

   localparam int          CNT_W   = $clog2(BUF_DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

   fetch_state_e     state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      req_pc_q, req_pc_d;
   logic             inflight_q, inflight_d;
   logic             drop_q, drop_d;

   logic             pop;
   logic             has_space;
   logic [CNT_W-1:0] space;
   logic [CNT_W-1:0] buf_count;
   logic             buf_full;
   logic             buf_empty;
   logic             redirect_bad;
   fetch_entry_t     push_entry;
   fetch_entry_t     head_entry;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic             misaligned_q, misaligned_d;
   assign redirect_bad = redirect & (redirect_pc[1:0] != 2'b00);
   assign misaligned   = misaligned_q;
`else
   assign redirect_bad = 1'b0;
`endif

   assign mem_we_re   = 1'b0;
   assign mem_mask    = 4'b1111;
   assign mem_address = pc_q[Address+1:2];

   assign instr_valid = ~buf_empty;
   assign instruction = head_entry.instr;
   assign instr_pc    = head_entry.pc;
   assign pop         = instr_valid & ready;

   // Credits: free slots not already promised to an in-flight response; a pop
   // this cycle frees one slot in time for the response to a new request.
   assign space     = DEPTH_C + CNT_W'(pop) - buf_count - CNT_W'(inflight_q);
   assign has_space = (space != '0);

   assign push_entry.instr = mem_data;
   assign push_entry.pc    = req_pc_q;

   fetch_buffer #(
      .BUF_DEPTH (BUF_DEPTH)
   ) u_buffer (
      .clk        (clk),
      .rst        (rst),
      .push       (mem_valid & ~drop_q),
      .pop        (pop & ~redirect),
      .flush      (redirect),
      .push_entry (push_entry),
      .head_entry (head_entry),
      .count      (buf_count),
      .full       (buf_full),
      .empty      (buf_empty)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: redirect overrides everything, otherwise follow credits.
   always_comb begin
      state_d = state_q;
      if (redirect) begin
         state_d = redirect_bad ? HALT : RUN;
      end else begin
         case (state_q)
            IDLE:      state_d = RUN;
            RUN, FULL: state_d = has_space ? RUN : FULL;
            HALT:      state_d = HALT;
            default:   state_d = IDLE;
         endcase
      end
   end

   // FSM outputs: request whenever fetching and a buffer slot is guaranteed.
   always_comb begin
      mem_request = 1'b0;
      if (!redirect && (state_q == RUN || state_q == FULL)) begin
         mem_request = has_space;
      end
   end

   // PC, request bookkeeping and stale-response drop.
   // With the fixed 1-cycle latency the in-flight response lands in the
   // redirect cycle itself and is removed by the flush; drop only arms if a
   // response is still outstanding after the redirect.
   always_comb begin
      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      inflight_d = mem_request;
      drop_d     = drop_q;
      if (redirect) begin
         pc_d   = align_pc(redirect_pc);
         drop_d = inflight_q & ~mem_valid;
      end else begin
         if (mem_request) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'(INSTR_BYTES);
         end
         if (mem_valid) begin
            drop_d = 1'b0;
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
      end
   end

`ifdef FETCH_MISALIGN_CHECK_EN
   // Misaligned flag follows the most recent redirect.
   always_comb begin
      misaligned_d = misaligned_q;
      if (redirect) begin
         misaligned_d = redirect_bad;
      end
   end

   // Misaligned flag register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         misaligned_q <= 1'b0;
      end else begin
         misaligned_q <= misaligned_d;
      end
   end
`endif

   // Responses only ever answer a request issued the cycle before.
   assert property (@(posedge clk) disable iff (rst) mem_valid |-> inflight_q);

   // Credits keep a response from arriving at a full buffer unless it pops.
   assert property (@(posedge clk) disable iff (rst)
                    !(mem_valid && !drop_q && buf_full && !pop && !redirect));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a 1-cycle memory model
// and an expected-entry queue checked on every decode handshake.
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          redirect = 1'b0;
   logic [31:0]   redirect_pc = '0;
   logic          ready = 1'b0;
   logic          mem_valid;
   logic [31:0]   mem_data;
   logic          mem_request;
   logic          mem_we_re;
   logic [3:0]    mem_mask;
   logic [AW-1:0] mem_address;
   logic          instr_valid;
   logic [31:0]   instruction;
   logic [31:0]   instr_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic          misaligned;
`endif

   int            checks = 0;
   int            passes = 0;
   logic [63:0]   exp_q[$];
   logic [31:0]   exp_pc = '0;

   fetch_unit #(
      .DataWidth (32),
      .Address   (AW),
      .RESET_PC  (32'h0000_0000),
      .BUF_DEPTH (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .ready       (ready),
      .mem_request (mem_request),
      .mem_we_re   (mem_we_re),
      .mem_mask    (mem_mask),
      .mem_address (mem_address),
      .mem_valid   (mem_valid),
      .mem_data    (mem_data),
      .instr_valid (instr_valid),
      .instruction (instruction),
      .instr_pc    (instr_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
      ,
      .misaligned  (misaligned)
`endif
   );

   // Clock.
   always #5 clk = ~clk;

   // Memory model: word at address a holds 0x1000_0000 + a, one cycle latency.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_valid <= 1'b0;
         mem_data  <= '0;
      end else begin
         mem_valid <= mem_request;
         mem_data  <= 32'h1000_0000 + {24'h0, mem_address};
      end
   end

   // Watchdog.
   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   function automatic logic [31:0] word_for(input logic [31:0] pc);
      return 32'h1000_0000 + {24'h0, pc[9:2]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // One cycle: drive inputs after the falling edge, then score the handshake
   // and the request that the upcoming rising edge will commit.
   task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
      logic [63:0] e;
      @(negedge clk);
      ready       = rdy;
      redirect    = redir;
      redirect_pc = rpc;
      #1;
      if (redir) begin
         chk("no_req_on_redirect", 32'(mem_request), 32'd0);
         exp_q.delete();
         exp_pc = rpc & ~32'h3;
      end else begin
         if (instr_valid && ready) begin
            if (exp_q.size() == 0) begin
               chk("pop_without_expected", 32'(instr_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("head_pc", instr_pc, e[31:0]);
               chk("head_instr", instruction, e[63:32]);
            end
         end
         if (mem_request) begin
            exp_q.push_back({word_for(exp_pc), exp_pc});
            exp_pc = exp_pc + 32'd4;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      ready    = 1'b0;
      redirect = 1'b0;
      #1;
      chk("rst_mem_request", 32'(mem_request), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_instruction", instruction, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
      chk("rst_mem_address", 32'(mem_address), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      exp_pc = 32'h0;
      #1;
      chk("idle_no_request", 32'(mem_request), 32'd0);
   endtask

   initial begin
      int nreq;

      // Streaming with ready held high: back-to-back addresses, no bubbles.
      do_reset();
      chk("const_we_re", 32'(mem_we_re), 32'd0);
      chk("const_mask", 32'(mem_mask), 32'hF);
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, 1'b0, '0);
         chk("stream_request", 32'(mem_request), 32'd1);
         chk("stream_address", 32'(mem_address), 32'(i - 1));
         chk("stream_valid", 32'(instr_valid), (i >= 3) ? 32'd1 : 32'd0);
      end

      // Back-pressure: exactly two requests, FULL, head held, then resume.
      do_reset();
      nreq = 0;
      for (int i = 1; i <= 5; i++) begin
         step(1'b0, 1'b0, '0);
         if (mem_request) nreq++;
      end
      chk("fill_req_count", 32'(nreq), 32'd2);
      chk("fill_state", 32'(dut.state_q), 32'(FULL));
      chk("fill_head_valid", 32'(instr_valid), 32'd1);
      chk("fill_head_pc", instr_pc, 32'h0);
      step(1'b1, 1'b0, '0);
      chk("resume_request", 32'(mem_request), 32'd1);
      chk("resume_address", 32'(mem_address), 32'd2);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);

      // Redirect while the request for 0x8 is in flight.
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
      chk("pre_redirect_address", 32'(mem_address), 32'd2);
      step(1'b1, 1'b1, 32'h40);
      step(1'b1, 1'b0, '0);
      chk("redirect_flushed", 32'(instr_valid), 32'd0);
      chk("redirect_request", 32'(mem_request), 32'd1);
      chk("redirect_address", 32'(mem_address), 32'h10);
      step(1'b1, 1'b0, '0);
      step(1'b1, 1'b0, '0);
      chk("redirect_head_pc", instr_pc, 32'h40);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);

      // Redirect together with a pop from a full buffer.
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
      chk("full_before_redirect", 32'(dut.state_q), 32'(FULL));
      step(1'b1, 1'b1, 32'h100);
      step(1'b1, 1'b0, '0);
      chk("full_redirect_empty", 32'(instr_valid), 32'd0);
      chk("full_redirect_address", 32'(mem_address), 32'h40);
      step(1'b1, 1'b0, '0);
      step(1'b1, 1'b0, '0);
      chk("full_redirect_head_pc", instr_pc, 32'h100);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);

      // Asynchronous reset pulse between clock edges.
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_request", 32'(mem_request), 32'd0);
      chk("async_rst_valid", 32'(instr_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      exp_pc = 32'h0;
      step(1'b1, 1'b0, '0);
      chk("restart_request", 32'(mem_request), 32'd1);
      chk("restart_address", 32'(mem_address), 32'd0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0);

`ifdef FETCH_MISALIGN_CHECK_EN
      // Misaligned redirect halts fetch until an aligned redirect.
      do_reset();
      chk("rst_misaligned", 32'(misaligned), 32'd0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
      step(1'b1, 1'b1, 32'h42);
      nreq = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0, '0);
         if (mem_request) nreq++;
      end
      chk("halt_misaligned", 32'(misaligned), 32'd1);
      chk("halt_no_requests", 32'(nreq), 32'd0);
      chk("halt_empty", 32'(instr_valid), 32'd0);
      step(1'b1, 1'b1, 32'h80);
      step(1'b1, 1'b0, '0);
      chk("unhalt_misaligned", 32'(misaligned), 32'd0);
      chk("unhalt_address", 32'(mem_address), 32'h20);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
